ex_completion_queue: RTL and testbench



---
 rtl/ex_cq_pkg.sv | 37 +++
 rtl/ex_cq_match.sv | 45 ++++
 rtl/ex_completion_queue.sv | 180 ++++++++++++++++++
 tb/tb_ex_completion_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_cq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_cq_pkg
// Purpose  : Shared types and constants for the in-order completion queue:
//            entry record, tag-width helper, operand query source indices.
// Revision : 1.0 - initial release
// ============================================================================
package ex_cq_pkg;

  // Field widths of the stored entry record; the queue's XLEN/REG_W/FLAG_W
  // parameters default to these and must not exceed them.
  localparam int CQ_XLEN   = 32;
  localparam int CQ_REG_W  = 5;
  localparam int CQ_FLAG_W = 5;

  // Operand query source indices
  localparam int Q_RS1 = 0;
  localparam int Q_RS2 = 1;
  localparam int Q_RS3 = 2;

  // Tag width for a queue of the given depth (at least one bit)
  function automatic int cq_tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One in-flight operation
  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [CQ_REG_W-1:0]  rd;
    logic                 fp;
    logic [CQ_XLEN-1:0]   data;
    logic [CQ_FLAG_W-1:0] flags;
  } cq_entry_t;

endpackage
`default_nettype wire

// File: rtl/ex_cq_match.sv
`default_nettype none
// ============================================================================
// Module   : ex_cq_match
// Purpose  : Youngest-match search for one operand query source. Walks the
//            entry ring from head (oldest) toward tail so the last hit found
//            is the youngest; returns it as a one-hot slot select.
// Revision : 1.0 - initial release
// ============================================================================
module ex_cq_match
  import ex_cq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REG_W = 5
) (
  input  logic [DEPTH-1:0]             valid_vec,
  input  logic [DEPTH-1:0]             fp_vec,
  input  logic [DEPTH*REG_W-1:0]       rd_flat,
  input  logic [cq_tag_w(DEPTH)-1:0]   head,
  input  logic [REG_W-1:0]             addr,
  input  logic                         fp,
  output logic [DEPTH-1:0]             sel
);

  localparam int TAG_W = cq_tag_w(DEPTH);

  logic [TAG_W-1:0] w_idx;

  // Oldest-to-youngest scan; later hits overwrite earlier ones. Integer x0 never matches.
  always_comb begin
    sel   = '0;
    w_idx = '0;
    if (fp || (addr != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = head + TAG_W'(k);
        if (valid_vec[w_idx] && (fp_vec[w_idx] == fp) &&
            (rd_flat[w_idx*REG_W +: REG_W] == addr)) begin
          sel        = '0;
          sel[w_idx] = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_completion_queue.sv
`default_nettype none
// ============================================================================
// Module   : ex_completion_queue
// Purpose  : In-order completion queue for variable-latency execute units.
//            Entries are allocated at issue, filled out of order by tag and
//            retired in program order. Answers operand hazard queries.
// Config   : EX_CQ_FWD_EN - when defined, completed in-flight results are
//            forwarded to queries instead of reported as hazards.
// Revision : 1.0 - initial release
// ============================================================================
module ex_completion_queue
  import ex_cq_pkg::*;
#(
  parameter int XLEN   = CQ_XLEN,
  parameter int REG_W  = CQ_REG_W,
  parameter int DEPTH  = 4,
  parameter int NQ     = 3,
  parameter int FLAG_W = CQ_FLAG_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [REG_W-1:0]             issue_rd,
  input  logic                         issue_fp,
  output logic [cq_tag_w(DEPTH)-1:0]   issue_tag,
  input  logic                         res_valid,
  input  logic [cq_tag_w(DEPTH)-1:0]   res_tag,
  input  logic [XLEN-1:0]              res_data,
  input  logic [FLAG_W-1:0]            res_flags,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [REG_W-1:0]             wb_rd,
  output logic                         wb_fp,
  output logic [XLEN-1:0]              wb_data,
  output logic [FLAG_W-1:0]            wb_flags,
  input  logic [NQ*REG_W-1:0]          q_addr,
  input  logic [NQ-1:0]                q_fp,
  output logic [NQ-1:0]                q_hazard,
  output logic [NQ-1:0]                q_fwd_valid,
  output logic [NQ*XLEN-1:0]           q_fwd_data,
  output logic                         tag_err
);

  localparam int TAG_W = cq_tag_w(DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  cq_entry_t        r_slot [0:DEPTH-1];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_tag_err;

  logic             w_issue;
  logic             w_retire;

  logic [DEPTH-1:0]       w_valid_vec;
  logic [DEPTH-1:0]       w_fp_vec;
  logic [DEPTH*REG_W-1:0] w_rd_flat;

  // Full/empty come from the registered count; a slot freed this cycle is not reusable until next
  assign issue_ready = (r_count != C_FULL);
  assign issue_tag   = r_tail;
  assign w_issue     = issue_valid && issue_ready;

  // Head presentation to writeback
  assign wb_valid = r_slot[r_head].valid && r_slot[r_head].done;
  assign wb_rd    = r_slot[r_head].rd;
  assign wb_fp    = r_slot[r_head].fp;
  assign wb_data  = r_slot[r_head].data;
  assign wb_flags = r_slot[r_head].flags;
  assign w_retire = wb_valid && wb_ready;

  assign tag_err  = r_tag_err;

  // Queue state: flush beats issue/result/retire; tag_err survives flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_slot[j] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_tag_err <= 1'b0;
    end else if (flush) begin
      for (int j = 0; j < DEPTH; j++) r_slot[j] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Retiring slot is always done, result slot never done, issue slot never valid: all disjoint
      if (w_retire) begin
        r_slot[r_head] <= '0;
        r_head         <= r_head + 1'b1;
      end
      if (res_valid) begin
        if (r_slot[res_tag].valid && !r_slot[res_tag].done) begin
          r_slot[res_tag].data  <= res_data;
          r_slot[res_tag].flags <= res_flags;
          r_slot[res_tag].done  <= 1'b1;
        end else begin
          r_tag_err <= 1'b1;
        end
      end
      if (w_issue) begin
        r_slot[r_tail].valid <= 1'b1;
        r_slot[r_tail].done  <= 1'b0;
        r_slot[r_tail].rd    <= issue_rd;
        r_slot[r_tail].fp    <= issue_fp;
        r_slot[r_tail].data  <= '0;
        r_slot[r_tail].flags <= '0;
        r_tail               <= r_tail + 1'b1;
      end
      case ({w_issue, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-slot field vectors for the match searchers
  for (genvar j = 0; j < DEPTH; j++) begin : g_flat
    assign w_valid_vec[j]               = r_slot[j].valid;
    assign w_fp_vec[j]                  = r_slot[j].fp;
    assign w_rd_flat[j*REG_W +: REG_W]  = r_slot[j].rd;
  end

  for (genvar i = 0; i < NQ; i++) begin : g_query
    logic [DEPTH-1:0] w_sel;

    ex_cq_match #(
      .DEPTH (DEPTH),
      .REG_W (REG_W)
    ) u_match (
      .valid_vec (w_valid_vec),
      .fp_vec    (w_fp_vec),
      .rd_flat   (w_rd_flat),
      .head      (r_head),
      .addr      (q_addr[i*REG_W +: REG_W]),
      .fp        (q_fp[i]),
      .sel       (w_sel)
    );

`ifdef EX_CQ_FWD_EN
    logic            w_pend;
    logic            w_rdy;
    logic [XLEN-1:0] w_fwd;

    // Youngest match: pending -> hazard, done -> forward its data
    always_comb begin
      w_pend = 1'b0;
      w_rdy  = 1'b0;
      w_fwd  = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (w_sel[j]) begin
          w_fwd = r_slot[j].data;
          if (r_slot[j].done) w_rdy  = 1'b1;
          else                w_pend = 1'b1;
        end
      end
    end

    assign q_hazard[i]                  = w_pend;
    assign q_fwd_valid[i]               = w_rdy;
    assign q_fwd_data[i*XLEN +: XLEN]   = w_fwd;
`else
    // Without forwarding any in-flight match stalls until it retires
    assign q_hazard[i] = |w_sel;
`endif
  end

`ifndef EX_CQ_FWD_EN
  assign q_fwd_valid = '0;
  assign q_fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_completion_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_completion_queue
// Purpose  : Directed self-checking bench for ex_completion_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_completion_queue;

  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 4;
  localparam int NQ     = 3;
  localparam int FLAG_W = 5;
  localparam int TAG_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [REG_W-1:0]       issue_rd;
  logic                   issue_fp;
  logic [TAG_W-1:0]       issue_tag;
  logic                   res_valid;
  logic [TAG_W-1:0]       res_tag;
  logic [XLEN-1:0]        res_data;
  logic [FLAG_W-1:0]      res_flags;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [REG_W-1:0]       wb_rd;
  logic                   wb_fp;
  logic [XLEN-1:0]        wb_data;
  logic [FLAG_W-1:0]      wb_flags;
  logic [NQ*REG_W-1:0]    q_addr;
  logic [NQ-1:0]          q_fp;
  logic [NQ-1:0]          q_hazard;
  logic [NQ-1:0]          q_fwd_valid;
  logic [NQ*XLEN-1:0]     q_fwd_data;
  logic                   tag_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_completion_queue #(
    .XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH), .NQ(NQ), .FLAG_W(FLAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_fp(issue_fp), .issue_tag(issue_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_flags(res_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_fp(wb_fp),
    .wb_data(wb_data), .wb_flags(wb_flags),
    .q_addr(q_addr), .q_fp(q_fp), .q_hazard(q_hazard), .q_fwd_valid(q_fwd_valid),
    .q_fwd_data(q_fwd_data), .tag_err(tag_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [REG_W-1:0] rd, input logic fp);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_fp    = fp;
    tick();
    issue_valid = 1'b0;
    issue_fp    = 1'b0;
  endtask

  task automatic result(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    res_valid = 1'b1;
    res_tag   = tag;
    res_data  = data;
    res_flags = 5'h01;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_vec++; if (issue_tag !== 2'd0) begin n_err++; $display("FAIL reset_issue_tag: got %0d want 0", issue_tag); end
    n_vec++; if (q_hazard !== 3'b000 || q_fwd_valid !== 3'b000) begin n_err++; $display("FAIL reset_query: got haz=%b fwd=%b want 000/000", q_hazard, q_fwd_valid); end
    n_vec++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || q_fwd_data !== '0) begin n_err++; $display("FAIL reset_data: got wb_data=%h wb_rd=%0d want 0", wb_data, wb_rd); end
    n_vec++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
  endtask

  task automatic test_single();
    q_addr[0 +: REG_W] = 5'd5;
    q_fp[0] = 1'b0;
    issue(5'd5, 1'b0);
    n_vec++; if (issue_tag !== 2'd1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL single_issue: got tag=%0d wbv=%b want 1/0", issue_tag, wb_valid); end
    n_vec++; if (q_hazard[0] !== 1'b1) begin n_err++; $display("FAIL single_pending_hazard: got %b want 1", q_hazard[0]); end
    result(2'd0, 32'h1234);
    n_vec++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234 || wb_fp !== 1'b0 || wb_flags !== 5'h01) begin
      n_err++; $display("FAIL single_wb: got v=%b rd=%0d data=%h fl=%h want 1/5/1234/01", wb_valid, wb_rd, wb_data, wb_flags); end
`ifdef EX_CQ_FWD_EN
    n_vec++; if (q_hazard[0] !== 1'b0 || q_fwd_valid[0] !== 1'b1 || q_fwd_data[0 +: XLEN] !== 32'h1234) begin
      n_err++; $display("FAIL single_fwd: got haz=%b fv=%b d=%h want 0/1/1234", q_hazard[0], q_fwd_valid[0], q_fwd_data[0 +: XLEN]); end
`else
    n_vec++; if (q_hazard[0] !== 1'b1 || q_fwd_valid[0] !== 1'b0) begin
      n_err++; $display("FAIL single_done_hazard: got haz=%b fv=%b want 1/0", q_hazard[0], q_fwd_valid[0]); end
`endif
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_vec++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || q_hazard[0] !== 1'b0) begin
      n_err++; $display("FAIL single_retired: got wbv=%b rdy=%b haz=%b want 0/1/0", wb_valid, issue_ready, q_hazard[0]); end
    q_addr = '0;
  endtask

  task automatic test_out_of_order();
    int order [4] = '{2, 0, 3, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (issue_tag !== TAG_W'(i)) begin n_err++; $display("FAIL ooo_alloc_tag: got %0d want %0d", issue_tag, i); end
      issue(REG_W'(10 + i), 1'b0);
    end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL ooo_full_ready: got %b want 0", issue_ready); end
    issue(5'd20, 1'b0);
    n_vec++; if (issue_ready !== 1'b0 || issue_tag !== 2'd0) begin n_err++; $display("FAIL ooo_full_issue: got rdy=%b tag=%0d want 0/0", issue_ready, issue_tag); end
    for (int k = 0; k < 4; k++) begin
      result(TAG_W'(order[k]), 32'hA000 + 32'(order[k]));
      if (k == 0) begin
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL ooo_head_not_done: got %b want 0", wb_valid); end
      end
      if (k == 1) begin
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL ooo_head_done: got %b want 1", wb_valid); end
      end
    end
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (wb_valid !== 1'b1 || wb_rd !== REG_W'(10 + k) || wb_data !== 32'hA000 + 32'(k)) begin
        n_err++; $display("FAIL ooo_retire_%0d: got v=%b rd=%0d data=%h want 1/%0d/%h", k, wb_valid, wb_rd, wb_data, 10 + k, 32'hA000 + 32'(k)); end
      tick();
    end
    wb_ready = 1'b0;
    n_vec++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || issue_tag !== 2'd0) begin
      n_err++; $display("FAIL ooo_drained: got wbv=%b rdy=%b tag=%0d want 0/1/0", wb_valid, issue_ready, issue_tag); end
  endtask

  task automatic test_hazard_fwd();
    do_reset();
    issue(5'd3, 1'b1);
    issue(5'd3, 1'b1);
    result(2'd0, 32'h4000_0000);
    q_addr[REG_W +: REG_W] = 5'd3; q_fp[1] = 1'b1;
    q_addr[0 +: REG_W]     = 5'd3; q_fp[0] = 1'b0;
    #1;
    n_vec++; if (q_hazard[1] !== 1'b1 || q_fwd_valid[1] !== 1'b0) begin
      n_err++; $display("FAIL fwd_youngest_pending: got haz=%b fv=%b want 1/0", q_hazard[1], q_fwd_valid[1]); end
    n_vec++; if (q_hazard[0] !== 1'b0) begin n_err++; $display("FAIL fwd_file_mismatch: got %b want 0", q_hazard[0]); end
    result(2'd1, 32'h3F80_0000);
`ifdef EX_CQ_FWD_EN
    n_vec++; if (q_hazard[1] !== 1'b0 || q_fwd_valid[1] !== 1'b1 || q_fwd_data[XLEN +: XLEN] !== 32'h3F80_0000) begin
      n_err++; $display("FAIL fwd_youngest_done: got haz=%b fv=%b d=%h want 0/1/3f800000", q_hazard[1], q_fwd_valid[1], q_fwd_data[XLEN +: XLEN]); end
`else
    n_vec++; if (q_hazard[1] !== 1'b1 || q_fwd_valid[1] !== 1'b0 || q_fwd_data !== '0) begin
      n_err++; $display("FAIL nofwd_youngest_done: got haz=%b fv=%b d=%h want 1/0/0", q_hazard[1], q_fwd_valid[1], q_fwd_data[XLEN +: XLEN]); end
`endif
    n_vec++; if (wb_fp !== 1'b1 || wb_data !== 32'h4000_0000) begin
      n_err++; $display("FAIL fwd_wb_head: got fp=%b data=%h want 1/40000000", wb_fp, wb_data); end
    q_addr = '0; q_fp = '0;
  endtask

  task automatic test_x0();
    do_reset();
    issue(5'd0, 1'b0);
    issue(5'd0, 1'b1);
    q_addr = '0; q_fp = 3'b100;
    #1;
    n_vec++; if (q_hazard[0] !== 1'b0) begin n_err++; $display("FAIL x0_int_never: got %b want 0", q_hazard[0]); end
    n_vec++; if (q_hazard[2] !== 1'b1) begin n_err++; $display("FAIL f0_matches: got %b want 1", q_hazard[2]); end
  endtask

  task automatic test_flush();
    issue(5'd7, 1'b0);
    n_vec++; if (issue_tag !== 2'd3) begin n_err++; $display("FAIL flush_pre_tag: got %0d want 3", issue_tag); end
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9;
    res_valid = 1'b1; res_tag = 2'd0; res_data = 32'hDEAD;
    tick();
    flush = 1'b0; issue_valid = 1'b0; res_valid = 1'b0;
    n_vec++; if (issue_tag !== 2'd0 || wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state: got tag=%0d wbv=%b rdy=%b want 0/0/1", issue_tag, wb_valid, issue_ready); end
    n_vec++; if (tag_err !== 1'b0 || q_hazard !== 3'b000) begin
      n_err++; $display("FAIL flush_side: got tag_err=%b haz=%b want 0/000", tag_err, q_hazard); end
    for (int i = 0; i < 3; i++) issue(REG_W'(i + 1), 1'b0);
    n_vec++; if (issue_ready !== 1'b1 || issue_tag !== 2'd3) begin
      n_err++; $display("FAIL flush_count_zeroed: got rdy=%b tag=%0d want 1/3", issue_ready, issue_tag); end
    q_fp = '0;
  endtask

  task automatic test_tag_err();
    do_reset();
    result(2'd2, 32'h55);
    n_vec++; if (tag_err !== 1'b1 || wb_valid !== 1'b0) begin n_err++; $display("FAIL tagerr_set: got err=%b wbv=%b want 1/0", tag_err, wb_valid); end
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n_vec++; if (tag_err !== 1'b1) begin n_err++; $display("FAIL tagerr_sticky: got %b want 1", tag_err); end
    issue(5'd4, 1'b0);
    result(2'd0, 32'h66);
    result(2'd0, 32'h77);
    n_vec++; if (wb_data !== 32'h66) begin n_err++; $display("FAIL tagerr_double_result: got %h want 66", wb_data); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (tag_err !== 1'b1) begin n_err++; $display("FAIL tagerr_sync_reset: got %b want 1", tag_err); end
    tick();
    rst_n = 1'b1;
    n_vec++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL tagerr_cleared: got %b want 0", tag_err); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_fp = 1'b0;
    res_valid = 1'b0; res_tag = '0; res_data = '0; res_flags = '0;
    wb_ready = 1'b0; q_addr = '0; q_fp = '0;
    #1;
    test_reset();
    test_single();
    test_out_of_order();
    test_hazard_fwd();
    test_x0();
    test_flush();
    test_tag_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
